// File: rtl/truth_table_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package truth_table_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    DONE
  } state_t;

  localparam int unsigned MAX_N_IN = 8;

  function automatic int unsigned rows_f(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_lut_mux.sv
// ROWS:1 single-bit select out of a truth-table vector.
module lut_mux #(
  parameter int unsigned ROWS  = 16,
  parameter int unsigned SEL_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
  input  logic [ROWS-1:0]  table_bits,
  input  logic [SEL_W-1:0] sel,
  output logic             bit_out
);

  always_comb begin
    bit_out = table_bits[sel];
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Programmable N_IN-input boolean function; sweeps all input rows on start.
// Define TRUTH_TABLE_MINTERM_ONLY_EN to present only the true rows during a sweep.
module truth_table_sweeper
  import truth_table_pkg::*;
#(
  parameter int unsigned N_IN = 4,
  parameter int unsigned ROWS = rows_f(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid,
  input  logic [ROWS-1:0] load_data,
  output logic            load_ready,
  input  logic            start,
  output logic            busy,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [N_IN-1:0] out_vec,
  output logic            out_s,
  output logic            done,
  output logic [N_IN:0]   ones_count,
  input  logic [N_IN-1:0] eval_in,
  output logic            eval_s
);

  localparam logic [N_IN:0]   LAST    = (N_IN+1)'(ROWS - 1);
  localparam logic [N_IN:0]   CNT_ONE = (N_IN+1)'(1);
  localparam logic [N_IN-1:0] IDX_ONE = N_IN'(1);

  state_t          state;
  logic [ROWS-1:0] lut;
  logic [N_IN:0]   counter;
  logic            loaded;

  logic handshake;
  logic advance;
  logic next_row_valid;
  logic first_row_valid;

  assign load_ready = (state == IDLE);
  assign out_vec    = counter[N_IN-1:0];

  lut_mux #(.ROWS(ROWS), .SEL_W(N_IN)) u_row_mux (
    .table_bits (lut),
    .sel        (counter[N_IN-1:0]),
    .bit_out    (out_s)
  );

  lut_mux #(.ROWS(ROWS), .SEL_W(N_IN)) u_eval_mux (
    .table_bits (lut),
    .sel        (eval_in),
    .bit_out    (eval_s)
  );

  always_comb begin
    handshake = out_valid && out_ready;
`ifdef TRUTH_TABLE_MINTERM_ONLY_EN
    // false rows have out_valid low and step forward without a handshake
    advance         = handshake || !out_valid;
    next_row_valid  = lut[counter[N_IN-1:0] + IDX_ONE];
    first_row_valid = load_valid ? load_data[0] : lut[0];
`else
    advance         = handshake;
    next_row_valid  = 1'b1;
    first_row_valid = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lut        <= '0;
      counter    <= '0;
      ones_count <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      loaded     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            lut    <= load_data;
            loaded <= 1'b1;
          end
          if (start && (loaded || load_valid)) begin
            counter    <= '0;
            ones_count <= '0;
            busy       <= 1'b1;
            out_valid  <= first_row_valid;
            state      <= SWEEP;
          end
        end
        SWEEP: begin
          if (handshake) begin
            ones_count <= ones_count + (N_IN+1)'(out_s);
          end
          if (advance) begin
            if (counter == LAST) begin
              state     <= DONE;
              busy      <= 1'b0;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              counter   <= counter + CNT_ONE;
              out_valid <= next_row_valid;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised self-checking bench for truth_table_sweeper with N_IN=4.
module tb_truth_table_sweeper;

  localparam int unsigned N_IN = 4;
  localparam int unsigned ROWS = 16;
`ifdef TRUTH_TABLE_MINTERM_ONLY_EN
  localparam bit MINTERM = 1'b1;
`else
  localparam bit MINTERM = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            load_valid;
  logic [ROWS-1:0] load_data;
  logic            load_ready;
  logic            start;
  logic            busy;
  logic            out_valid;
  logic            out_ready;
  logic [N_IN-1:0] out_vec;
  logic            out_s;
  logic            done;
  logic [N_IN:0]   ones_count;
  logic [N_IN-1:0] eval_in;
  logic            eval_s;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [ROWS-1:0] model_lut;

  truth_table_sweeper #(.N_IN(N_IN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .start      (start),
    .busy       (busy),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vec    (out_vec),
    .out_s      (out_s),
    .done       (done),
    .ones_count (ones_count),
    .eval_in    (eval_in),
    .eval_s     (eval_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int unsigned popcount(input logic [ROWS-1:0] v);
    int unsigned c = 0;
    for (int i = 0; i < ROWS; i++) c += v[i];
    return c;
  endfunction

  // mode 0: ready always, 1: ready pattern 1,0,0,... , 2: random ready
  task automatic run_sweep(input logic [ROWS-1:0] lut_v, input int unsigned mode,
                           input bit same_cycle_load, input bit try_lockout);
    int unsigned exp_q[$];
    int unsigned got_q[$];
    int unsigned cyc;
    int unsigned k;
    bit got_done;
    bit stalled;
    logic [N_IN-1:0] held_vec;

    for (int unsigned v = 0; v < ROWS; v++)
      if (!MINTERM || lut_v[v]) exp_q.push_back(v);

    if (!same_cycle_load) begin
      load_valid = 1'b1;
      load_data  = lut_v;
      @(posedge clk); #1;
      load_valid = 1'b0;
    end else begin
      load_valid = 1'b1;
      load_data  = lut_v;
    end
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0;
    start      = 1'b0;
    model_lut  = lut_v;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("first_valid", {31'd0, out_valid}, MINTERM ? {31'd0, lut_v[0]} : 32'd1);

    cyc = 0; k = 0; got_done = 1'b0; stalled = 1'b0; held_vec = '0;
    while (cyc < 200 && !got_done) begin
      if (done) begin
        got_done = 1'b1;
      end else begin
        check("busy_in_sweep", {31'd0, busy}, 32'd1);
        if (stalled && out_valid) check("stall_hold", {28'd0, out_vec}, {28'd0, held_vec});
        case (mode)
          0:       out_ready = 1'b1;
          1:       out_ready = (k % 3 == 0);
          default: out_ready = 1'($urandom_range(0, 1));
        endcase
        k++;
        if (try_lockout && cyc == 5) begin
          load_valid = 1'b1;
          load_data  = '0;
          start      = 1'b1;
        end
        if (out_valid && out_ready) begin
          got_q.push_back(int'(out_vec));
          check("row_s", {31'd0, out_s}, {31'd0, model_lut[out_vec]});
        end
        stalled  = out_valid && !out_ready;
        held_vec = out_vec;
        eval_in  = N_IN'($urandom_range(0, ROWS - 1));
        #1;
        check("eval_sweep", {31'd0, eval_s}, {31'd0, model_lut[eval_in]});
        @(posedge clk); #1;
        load_valid = 1'b0;
        start      = 1'b0;
        cyc++;
      end
    end

    if (!got_done) check("done_timeout", 32'd0, 32'd1);
    if (mode == 0) check("sweep_len", cyc, ROWS);
    check("row_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("row_vec", got_q[i], exp_q[i]);
    check("ones_count", {27'd0, ones_count}, popcount(lut_v));
    check("done_valid_low", {31'd0, out_valid}, 32'd0);
    check("done_busy_low", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check("done_pulse_end", {31'd0, done}, 32'd0);
    check("idle_load_ready", {31'd0, load_ready}, 32'd1);
    check("ones_hold", {27'd0, ones_count}, popcount(lut_v));
  endtask

  initial begin
    int unsigned guard;
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; start = 1'b0;
    out_ready = 1'b0; eval_in = '0; model_lut = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_ones", {27'd0, ones_count}, 32'd0);
    check("rst_load_ready", {31'd0, load_ready}, 32'd1);
    check("rst_eval", {31'd0, eval_s}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_unloaded_busy", {31'd0, busy}, 32'd0);
    check("start_unloaded_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("start_unloaded_idle", {31'd0, load_ready}, 32'd1);

    run_sweep(16'h3F0F, 0, 1'b0, 1'b0);
    run_sweep(16'h3F0F, 1, 1'b1, 1'b0);
    run_sweep(16'h3F0F, 2, 1'b0, 1'b1);
    eval_in = 4'hC;
    #1;
    check("lockout_eval_c", {31'd0, eval_s}, 32'd1);
    run_sweep(16'h8001, 0, 1'b0, 1'b0);
    run_sweep(16'h0000, 0, 1'b1, 1'b0);
    run_sweep(16'hFFFF, 1, 1'b0, 1'b0);
    for (int t = 0; t < 4; t++)
      run_sweep(ROWS'($urandom), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), 1'b0);

    load_valid = 1'b1; load_data = 16'h3F0F; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    load_valid = 1'b0; start = 1'b0;
    guard = 0;
    while (out_vec != 4'd7 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check("reach_row7", {28'd0, out_vec}, 32'd7);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_ones", {27'd0, ones_count}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_load_ready", {31'd0, load_ready}, 32'd1);
    for (int unsigned v = 0; v < ROWS; v++) begin
      eval_in = N_IN'(v);
      #1;
      check("midrst_eval", {31'd0, eval_s}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("midrst_needs_load", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential, parametrised successor to our fixed 4-input boolean-expression blocks.
- Holds a programmable N_IN-input boolean function as a 2^N_IN-bit truth-table (LUT) register.
- On `start`, sweeps every input combination in ascending order and emits one {input vector, result} row per handshake, then reports the minterm count.
- Replaces hand-written per-expression modules and hand-enumerated stimulus lists in lab and verification benches.

Parameters:
- N_IN, 4, number of boolean inputs; legal range 1..8.
- ROWS, 2**N_IN, derived row count; not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- load_valid  input  1  LUT load request
- load_data  input  ROWS  truth table; bit i = f(input vector i)
- load_ready  output  1  high only in IDLE
- start  input  1  begin sweep; sampled in IDLE only
- busy  output  1  high in SWEEP
- out_valid  output  1  row available
- out_ready  input  1  consumer accepts row
- out_vec  output  N_IN  current input vector; MSB = first variable
- out_s  output  1  f(out_vec)
- done  output  1  one-cycle pulse after the last row is accepted
- ones_count  output  N_IN+1  number of true rows seen in the last or current sweep
- eval_in  input  N_IN  direct lookup address
- eval_s  output  1  combinational lut[eval_in], available in any state

Behaviour:
- Reset and clocking: reset is asynchronous and active-low on `rst_n`; single clock domain on `clk`.
- Reset values: lut=0, state=IDLE, counter=0, ones_count=0, out_valid=0, busy=0, done=0, loaded=0. `load_ready` is 1 after reset, since the block is in IDLE.
- States: IDLE, SWEEP, DONE.
- IDLE:
  - load_valid && load_ready: lut <= load_data, loaded <= 1.
  - start && loaded: counter <= 0, ones_count <= 0, go to SWEEP. Load and start in the same cycle: the load takes effect and the sweep starts with the new LUT.
  - start && !loaded: ignored; stay in IDLE.
- SWEEP:
  - out_valid=1, out_vec=counter, out_s=lut[counter].
  - Handshake when out_valid && out_ready: ones_count += out_s.
  - If counter==ROWS-1, go to DONE; otherwise counter++.
  - Without out_ready, out_vec and out_s hold stable.
  - load_valid and start are ignored.
- DONE: done=1 for exactly one cycle, out_valid=0, then IDLE. ones_count and lut hold until the next start.
- Latency: first row is valid the cycle after start is accepted. With out_ready tied high, a full sweep takes ROWS cycles plus 1 DONE cycle.
- Widths: the counter has N_IN+1 bits internally; wrap from ROWS-1 never occurs because the FSM exits first. ones_count maximum = ROWS, which fits in N_IN+1 bits.
- Reset mid-sweep: immediate return to IDLE, outputs at their reset values, LUT cleared, and `loaded` must be re-established by a new load.
- eval_s is independent of the FSM and changes in the same cycle as eval_in or lut.

Optional Feature:
- Macro: TRUTH_TABLE_MINTERM_ONLY_EN.
- Defined:
  - In SWEEP, rows with lut[counter]==0 are skipped: counter advances one per cycle with out_valid=0.
  - Only true rows are presented; ones_count still counts them.
  - An all-zero LUT gives ROWS skip cycles, then DONE with ones_count=0 and no rows emitted.
- Undefined: every row is emitted, as above.

Decomposition:
- Package truth_table_pkg:
  - state enum {IDLE, SWEEP, DONE}
  - MAX_N_IN=8
  - function rows_f(n) = 1<<n
- Sub-module lut_mux: parametrised ROWS:1 bit select. Instantiate it twice, once for out_s and once for eval_s.

Test Plan:
- Reset: rst_n=0 for 2 cycles -> all outputs 0, load_ready=1; start before any load -> stays in IDLE, busy=0.
- Load and sweep: N_IN=4, load 16'h3F0F, start, out_ready=1 -> rows 0..15 emitted, out_s bits match 0x3F0F, done pulses once, ones_count=10.
- Backpressure: same LUT, out_ready toggling 1,0,0,1... -> no row lost or duplicated, out_vec stable while stalled, ones_count=10.
- Busy lockout: load 16'h0000 and assert start mid-sweep -> ignored; after done, eval_in=4'hC gives eval_s=1 (old LUT retained).
- Reset mid-sweep: assert rst_n=0 at row 7 -> out_valid=0, ones_count=0, eval_s=0 for all eval_in.
- With TRUTH_TABLE_MINTERM_ONLY_EN: LUT 16'h8001 -> exactly two rows emitted (vec 0 and vec 15), ones_count=2; LUT 0 -> no rows, done after 16 cycles.
